// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write-back path.
package regfile_pkg;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// In-order FIFO of pending write-back entries.
// Exposes every slot, its valid bit and the read pointer so the parent can scan by age.
module wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    input  logic            flush,
    output wb_entry_t       head,
    output logic [CW-1:0]   count,
    output logic [PW-1:0]   rd_ptr,
    output wb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] valid
);
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push && !flush) entries[wr_ptr] <= push_entry;
    end

    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PW'(i) - rd_ptr;
            valid[i] = (CW'(offset) < count);
        end
    end

    assign head = entries[rd_ptr];
endmodule

// File: rtl/regfile_writeback.sv
// Write side of the register file: accepts ALU results, queues them, issues one
// registered write per cycle and forwards not-yet-committed values to operand fetch.
module regfile_writeback #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [ADDR_W-1:0] res_dest,
    input  logic [DATA_W-1:0] res_data,
    input  logic              flush,
    input  logic              wr_hold,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [CW-1:0]     pending
);
    import regfile_pkg::*;

    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    idx;
    logic             push;
    logic             pop;

    assign res_ready  = rst_n && (pending != CW'(DEPTH)) && !flush;
    // Writes to R0 complete the handshake but are dropped here.
    assign push       = res_valid && res_ready && (res_dest != ZERO_REG);
    assign pop        = (pending != '0) && !wr_hold && !flush;
    assign push_entry = '{dest: res_dest, data: res_data};

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .count      (pending),
        .rd_ptr     (rd_ptr),
        .entries    (entries),
        .valid      (valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else if (flush) begin
            we <= 1'b0;
        end else if (pop) begin
            we <= 1'b1;
            wa <= head.dest;
            wd <= head.data;
        end else begin
            we <= 1'b0;
        end
    end

    // Scan oldest to newest so the youngest matching entry overwrites older ones.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = '0;
        if (we && wa == a1 && a1 != ZERO_REG) begin
            fwd1_hit  = 1'b1;
            fwd1_data = wd;
        end
        if (we && wa == a2 && a2 != ZERO_REG) begin
            fwd2_hit  = 1'b1;
            fwd2_data = wd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (valid[idx] && entries[idx].dest == a1 && a1 != ZERO_REG) begin
                fwd1_hit  = 1'b1;
                fwd1_data = entries[idx].data;
            end
            if (valid[idx] && entries[idx].dest == a2 && a2 != ZERO_REG) begin
                fwd2_hit  = 1'b1;
                fwd2_data = entries[idx].data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with hand-computed expectations.
module tb_regfile_writeback;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_dest;
    logic [7:0] res_data;
    logic       flush;
    logic       wr_hold;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] a1, a2;
    logic       fwd1_hit, fwd2_hit;
    logic [7:0] fwd1_data, fwd2_data;
    logic [1:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    regfile_writeback #(.DEPTH(2), .DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_dest  (res_dest),
        .res_data  (res_data),
        .flush     (flush),
        .wr_hold   (wr_hold),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .a1        (a1),
        .a2        (a2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] d, input logic [7:0] v);
        res_valid = 1'b1;
        res_dest  = d;
        res_data  = v;
    endtask

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; res_dest = '0; res_data = '0;
        flush = 1'b0; wr_hold = 1'b0; a1 = '0; a2 = '0;
        @(negedge clk);
        check("rst_we", we, 0);
        check("rst_pending", pending, 0);
        check("rst_ready", res_ready, 0);
        rst_n = 1'b1;
        #1 check("rel_ready", res_ready, 1);
        @(negedge clk);

        // Single write
        offer(3'd5, 8'hA3);
        check("t2_ready", res_ready, 1);
        step();
        res_valid = 1'b0;
        check("t2_pend1", pending, 1);
        check("t2_we_early", we, 0);
        step();
        check("t2_we", we, 1);
        check("t2_wa", wa, 5);
        check("t2_wd", wd, 8'hA3);
        check("t2_pend0", pending, 0);
        step();
        check("t2_we_once", we, 0);

        // Back-pressure
        wr_hold = 1'b1;
        offer(3'd3, 8'h11); step();
        offer(3'd4, 8'h22); step();
        res_valid = 1'b0;
        check("t3_pend", pending, 2);
        check("t3_ready", res_ready, 0);
        check("t3_we_hold", we, 0);
        wr_hold = 1'b0;
        step();
        check("t3_we1", we, 1);
        check("t3_wa1", wa, 3);
        check("t3_wd1", wd, 8'h11);
        step();
        check("t3_we2", we, 1);
        check("t3_wa2", wa, 4);
        check("t3_wd2", wd, 8'h22);
        check("t3_pend0", pending, 0);
        step();
        check("t3_idle", we, 0);

        // Forwarding, newest first
        wr_hold = 1'b1;
        offer(3'd2, 8'h10); step();
        offer(3'd2, 8'h20); step();
        res_valid = 1'b0;
        a1 = 3'd2; a2 = 3'd6;
        #1;
        check("t4_hit1", fwd1_hit, 1);
        check("t4_data1", fwd1_data, 8'h20);
        check("t4_hit2", fwd2_hit, 0);
        check("t4_data2", fwd2_data, 0);
        wr_hold = 1'b0;
        step();
        check("t4_wd_old", wd, 8'h10);
        check("t4_q_over_out", fwd1_data, 8'h20);
        step();
        check("t4_wd_new", wd, 8'h20);
        check("t4_out_hit", fwd1_hit, 1);
        check("t4_out_data", fwd1_data, 8'h20);
        a2 = 3'd2;
        #1 check("t4_out_data2", fwd2_data, 8'h20);
        step();
        check("t4_done_hit", fwd1_hit, 0);
        check("t4_done_data", fwd1_data, 0);

        // R0 discard
        a1 = 3'd0; a2 = 3'd0;
        offer(3'd0, 8'hFF);
        check("t5_ready", res_ready, 1);
        step();
        res_valid = 1'b0;
        check("t5_pend", pending, 0);
        check("t5_hit", fwd1_hit, 0);
        step();
        check("t5_we", we, 0);

        // Flush
        wr_hold = 1'b1;
        offer(3'd1, 8'h31); step();
        check("t6_ready_p1", res_ready, 1);
        flush = 1'b1;
        #1 check("t6_ready_flush_p1", res_ready, 0);
        flush = 1'b0;
        offer(3'd7, 8'h32); step();
        check("t6_pend2", pending, 2);
        offer(3'd6, 8'h77);
        flush = 1'b1; wr_hold = 1'b0;
        #1 check("t6_ready_flush", res_ready, 0);
        step();
        flush = 1'b0; res_valid = 1'b0;
        check("t6_pend0", pending, 0);
        check("t6_we0", we, 0);
        step();
        check("t6_no_write", we, 0);
        check("t6_pend_after", pending, 0);

        // Reset mid-stream with two pending, then with a write in flight
        wr_hold = 1'b1;
        offer(3'd3, 8'h44); step();
        offer(3'd4, 8'h55); step();
        res_valid = 1'b0;
        check("t1_pend2", pending, 2);
        rst_n = 1'b0;
        #1;
        check("t1_we", we, 0);
        check("t1_pend", pending, 0);
        check("t1_ready", res_ready, 0);
        step();
        check("t1_wa", wa, 0);
        check("t1_wd", wd, 0);
        rst_n = 1'b1; wr_hold = 1'b0;
        #1 check("t1_ready_rel", res_ready, 1);
        @(negedge clk);
        check("t1_no_write", we, 0);
        offer(3'd6, 8'h66); step();
        res_valid = 1'b0;
        step();
        check("t1_inflight", we, 1);
        rst_n = 1'b0;
        #1;
        check("t1_inflight_we", we, 0);
        check("t1_inflight_wd", wd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t1_dropped", we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
